// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 5-stage 8-bit core: owns pc and the IF/ID register,
// resolves jumps in ID with a one-bubble squash and drains before halting.
module fetch_sequencer #(
  parameter int PC_W      = 8,
  parameter int PROG_LEN  = 6,
  parameter int DRAIN_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            hold,
  input  logic [PC_W-1:0] instr_in,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] ifid_instr,
  output logic [PC_W-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic            flush,
  output logic            illegal,
  output logic [1:0]      state,
  output logic            halted
);

  localparam int CNT_W = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [PC_W-1:0]  PROG_END = PC_W'(PROG_LEN);
  localparam logic [CNT_W-1:0] CNT_LD   = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10, HALT = 2'b11} state_t;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
    logic            valid;
  } ifid_t;

  state_t          st_q, st_d;
  ifid_t           ifid_q, ifid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op;

  assign op = ifid_q.instr[PC_W-1:PC_W-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      pc_q   <= '0;
      ifid_q <= '0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      ill_q  <= ill_d;
      cnt_q  <= cnt_d;
    end
  end

  // Hold freezes everything by leaving every next-value at its default.
  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    ifid_d = ifid_q;
    ill_d  = ill_q;
    cnt_d  = cnt_q;
    flush  = 1'b0;
    if (!hold) begin
      unique case (st_q)
        IDLE: if (start) st_d = RUN;
        RUN: begin
          if (ifid_q.valid && op == 2'b11) begin
            // Redirect stays within the current 64-word page.
            pc_d         = {pc_q[PC_W-1:6], ifid_q.instr[5:0]};
            ifid_d.valid = 1'b0;
            flush        = 1'b1;
          end else if (ifid_q.valid && op == 2'b10) begin
            ill_d        = 1'b1;
            ifid_d.valid = 1'b0;
            st_d         = DRAIN;
            cnt_d        = CNT_LD;
          end else if (pc_q >= PROG_END) begin
            ifid_d.valid = 1'b0;
            st_d         = DRAIN;
            cnt_d        = CNT_LD;
          end else begin
            ifid_d.instr = instr_in;
            ifid_d.pc    = pc_q;
            ifid_d.valid = 1'b1;
            pc_d         = pc_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) st_d = HALT;
          else             cnt_d = cnt_q - 1'b1;
        end
        HALT: ;
      endcase
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_valid = ifid_q.valid;
  assign illegal    = ill_q;
  assign state      = st_q;
  assign halted     = (st_q == HALT);

endmodule
